// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Widest operand the divider supports; the divide-by-zero quotient is sliced from this.
  localparam int unsigned DIV_MAX_W = 64;

  // Quotient reported on divide-by-zero: all ones at any supported width.
  localparam logic [DIV_MAX_W-1:0] DIV_DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational N-bit ripple-borrow subtractor: o_diff = i_a - i_b - i_bin.
module div_sub_stage #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bin,
  output logic [N-1:0] o_diff,
  output logic         o_bout
);

  logic [N:0] w_borrow;

  // Ripple the borrow from LSB to MSB, one full-subtractor cell per bit.
  always_comb begin
    w_borrow    = '0;
    o_diff      = '0;
    w_borrow[0] = i_bin;
    for (int unsigned i = 0; i < N; i++) begin
      o_diff[i]     = i_a[i] ^ i_b[i] ^ w_borrow[i];
      w_borrow[i+1] = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & w_borrow[i]);
    end
  end

  assign o_bout = w_borrow[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned multi-cycle restoring divider: one trial subtraction per clock,
// W iterations per result, start/busy/done handshake.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         dbz
);

  localparam int unsigned CW = $clog2(W + 1);

  div_state_e    r_state, w_state_nxt;
  logic [W-1:0]  r_wq, w_wq_nxt;
  logic [W:0]    r_wr, w_wr_nxt;
  logic [W-1:0]  r_d, w_d_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [W-1:0]  r_q, w_q_nxt;
  logic [W-1:0]  r_r, w_r_nxt;
  logic          r_dbz, w_dbz_nxt;

  logic [W:0]    w_s;
  logic [W:0]    w_diff;
  logic          w_bout;
  logic [W:0]    w_wr_iter;
  logic [W-1:0]  w_wq_iter;

  // The remainder never reaches 2^W, so its top bit is never read back.
  logic          w_unused_wr_msb;
  assign w_unused_wr_msb = r_wr[W];

  assign w_s = {r_wr[W-1:0], r_wq[W-1]};

  div_sub_stage #(
    .N (W + 1)
  ) u_sub (
    .i_a    (w_s),
    .i_b    ({1'b0, r_d}),
    .i_bin  (1'b0),
    .o_diff (w_diff),
    .o_bout (w_bout)
  );

  // Restoring step: keep the difference when no borrow, else keep the shifted remainder.
  always_comb begin
    w_wr_iter = w_bout ? w_s : w_diff;
    w_wq_iter = {r_wq[W-2:0], ~w_bout};
  end

  // State register plus all datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_wq    <= '0;
      r_wr    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wq    <= w_wq_nxt;
      r_wr    <= w_wr_nxt;
      r_d     <= w_d_nxt;
      r_cnt   <= w_cnt_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_dbz   <= w_dbz_nxt;
    end
  end

  // Next-state and datapath update; IDLE and DONE share the accept path for back-to-back issue.
  always_comb begin
    w_state_nxt = r_state;
    w_wq_nxt    = r_wq;
    w_wr_nxt    = r_wr;
    w_d_nxt     = r_d;
    w_cnt_nxt   = r_cnt;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_dbz_nxt   = r_dbz;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_wq_nxt  = A;
          w_d_nxt   = B;
          w_wr_nxt  = '0;
          w_cnt_nxt = CW'(W);
          if (B == '0) begin
            w_state_nxt = DONE;
            w_q_nxt     = DIV_DBZ_QUOTIENT[W-1:0];
            w_r_nxt     = A;
            w_dbz_nxt   = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end else if (r_state == DONE) begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        w_wr_nxt  = w_wr_iter;
        w_wq_nxt  = w_wq_iter;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = DONE;
          w_q_nxt     = w_wq_iter;
          w_r_nxt     = w_wr_iter[W-1:0];
          w_dbz_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign Q    = r_q;
  assign R    = r_r;
  assign dbz  = r_dbz;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider against integer division.
module tb_seq_restoring_divider;

  localparam int unsigned W    = 4;
  localparam int unsigned MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dbz;

  int unsigned checks;
  int unsigned errors;

  seq_restoring_divider #(
    .W (W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a start at the current falling edge; return at the falling edge after acceptance.
  task automatic launch(input int unsigned a, input int unsigned b);
    start = 1'b1;
    A     = W'(a);
    B     = W'(b);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
  endtask

  // Wait for done and compare against plain integer division.
  task automatic wait_result(input int unsigned a, input int unsigned b, input bit inject);
    int unsigned n        = 0;
    int unsigned busy_cnt = 0;
    int unsigned exp_lat  = (b == 0) ? 0 : W;
    int unsigned exp_q    = (b == 0) ? MAXV : a / b;
    int unsigned exp_r    = (b == 0) ? a : a % b;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (inject && n == 1) begin
        start = 1'b1;
        A     = W'(3);
        B     = W'(2);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("latency", n, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("done_high", done, 1);
    check("busy_in_done", busy, 0);
    check("quotient", Q, exp_q);
    check("remainder", R, exp_r);
    check("dbz", dbz, (b == 0) ? 1 : 0);
  endtask

  // Full operation followed by one idle cycle checking the done pulse width and output hold.
  task automatic div_op(input int unsigned a, input int unsigned b);
    int unsigned q_hold;
    int unsigned r_hold;
    launch(a, b);
    wait_result(a, b, 1'b0);
    q_hold = Q;
    r_hold = R;
    @(posedge clk);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("q_held", Q, q_hold);
    check("r_held", R, r_hold);
  endtask

  initial begin
    int unsigned done_seen;
    int unsigned q_i;
    int unsigned r_i;
    int unsigned ra;
    int unsigned rb;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;

    #2;
    check("rst_q", Q, 0);
    check("rst_r", R, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    div_op(9, 5);
    div_op(7, 9);
    div_op(15, 15);
    div_op(0, 1);
    div_op(13, 0);
    div_op(9, 5);

    // Back-to-back: hold start through the DONE cycle.
    launch(10, 3);
    wait_result(10, 3, 1'b0);
    start = 1'b1;
    A     = W'(15);
    B     = W'(1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_no_bubble", busy, 1);
    wait_result(15, 1, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // Start pulse mid-RUN is ignored.
    launch(12, 5);
    wait_result(12, 5, 1'b1);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset during the second RUN cycle.
    launch(14, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_q", Q, 0);
    check("arst_r", R, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dbz", dbz, 0);
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("no_done_after_rst", done_seen, 0);
    div_op(9, 5);

    // Randomised operands, divide-by-zero included.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom_range(MAXV, 0);
      rb = $urandom_range(MAXV, 0);
      div_op(ra, rb);
    end

    // Exhaustive sweep of the division identity.
    for (int a = 0; a <= int'(MAXV); a++) begin
      for (int b = 1; b <= int'(MAXV); b++) begin
        launch(a, b);
        wait_result(a, b, 1'b0);
        q_i = Q;
        r_i = R;
        check("inv_eq", q_i * b + r_i, a);
        check("inv_lt", (r_i < b) ? 1 : 0, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Unsigned multi-cycle restoring divider that time-shares one parallel subtractor stage across W iterations. A start/busy/done handshake sequences it. Each cycle it performs one trial subtraction of the divisor from the shifted partial remainder, using the borrow-out to decide the quotient bit. It sits beside the combinational adder/subtractor library as the first sequenced arithmetic unit built on the subtractor.

Parameters:
W, 4, operand width in bits for dividend, divisor, quotient and remainder.
CW, $clog2(W+1), iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only when the FSM is in IDLE or DONE
A  input  W  dividend; captured on an accepted start
B  input  W  divisor; captured on an accepted start
Q  output  W  quotient; registered; holds the last result
R  output  W  remainder; registered; holds the last result
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when Q/R/dbz update
dbz  output  1  divide-by-zero flag for the last result; held until the next result

Behaviour:
- Interface: single clock domain on clk. rst is asynchronous and active-high.
- Reset: state=IDLE; Q=0, R=0, busy=0, done=0, dbz=0; working registers and counter all 0. Asserting rst mid-operation aborts the division immediately. No done pulse follows, and Q/R read 0.
- States: IDLE, RUN, DONE.
- IDLE, or DONE with start=1: capture A into the working quotient wq and B into the divisor register d; clear the working remainder wr (W+1 bits); set cnt=W.
  - If B==0: go to DONE on the same edge. Set Q=all-ones, R=A, dbz=1. No iterations run.
  - Otherwise: go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE: done=1 for exactly this one cycle. With start=0, go to IDLE next edge. With start=1, accept the new operation as described above (back-to-back issue, no idle bubble).
- RUN, one iteration per edge:
  - s = {wr[W-1:0], wq[W-1]}, which is W+1 bits.
  - {borrow, diff} = s - {1'b0, d}, computed by the subtractor stage with borrow-in 0.
  - If borrow==0: wr=diff and the new quotient LSB is 1. Otherwise: wr=s (restore) and the new LSB is 0.
  - wq = {wq[W-2:0], new LSB}.
  - cnt decrements each iteration. The edge where cnt==1 is the last iteration. On that edge, go to DONE and register Q=final wq, R=final wr[W-1:0], dbz=0.
- start while in RUN is ignored and has no effect on the operation in flight.
- Latency (start accepted at edge k):
  - Normal: done is high in the cycle after edge k+W.
  - B==0: done is high in the cycle after edge k.
  - Throughput: one result per W+1 cycles.
- busy=1 only in RUN; it is 0 in IDLE and DONE.
- Outputs change only on entry to DONE (or on reset). A, B and start may change freely after acceptance.
- Invariant for B!=0: A == Q*B + R and R < B. Widths never overflow because wr is W+1 bits.

Decomposition:
- Shared package div_pkg: state enum (IDLE, RUN, DONE), and a localparam for the divide-by-zero quotient value (all-ones).
- One sub-module, div_sub_stage: a combinational (W+1)-bit parallel subtractor with inputs a, b and borrow-in; outputs difference and borrow-out. It reuses the team's ripple-borrow subtractor structure at parameterised width.
- The FSM, counter and shift registers stay in the top module.

Test Plan:
- W=4, A=9 (1001), B=5 (0101), start pulse -> busy for 4 cycles, then done=1 for one cycle with Q=1, R=4, dbz=0.
- A=7, B=9 -> Q=0, R=7. A=15, B=15 -> Q=1, R=0. A=0, B=1 -> Q=0, R=0. Each takes exactly W+1 cycles from start to done.
- A=13, B=0 -> done in the cycle after acceptance, busy never high, dbz=1, Q=15, R=13. The next valid division clears dbz to 0.
- Back-to-back: start held during the DONE cycle with A=15, B=1 -> new operation accepted with no IDLE cycle, giving Q=15, R=0. A start pulse with A=3, B=2 mid-RUN is ignored, and the in-flight result is unchanged.
- rst asserted asynchronously (between edges) on the 2nd RUN cycle -> Q, R, busy, done and dbz read 0 immediately. No done pulse follows. A fresh start after release (A=9, B=5) gives Q=1, R=4.
- Exhaustive sweep, all A, B in 0..15 with B!=0 -> for every pair, A==Q*B+R and R<B.
